// File: rtl/mm_cmd_responder_if.sv
// Register-bank side of the command mailbox: command/argument words in,
// status/result/timestamp words out.
interface mm_cmd_responder_if;
  logic [31:0] cmd_i;
  logic [31:0] arg0_i;
  logic [31:0] arg1_i;
  logic [31:0] status_o;
  logic [31:0] result0_o;
  logic [31:0] result1_o;
  logic [31:0] timestamp_lo_o;

  modport slave (
    input  cmd_i, arg0_i, arg1_i,
    output status_o, result0_o, result1_o, timestamp_lo_o
  );

  modport master (
    output cmd_i, arg0_i, arg1_i,
    input  status_o, result0_o, result1_o, timestamp_lo_o
  );
endinterface

// File: rtl/mm_cmd_responder.sv
// Fabric-side mailbox responder: detects a toggle of the command sequence bit,
// executes scratch/add/delay/timestamp commands and reports status and results.
module mm_cmd_responder #(
  parameter int SCRATCH_DEPTH = 8,
  parameter int DONE_CNT_W    = 16
) (
  input  logic           clk_clk,
  input  logic           reset_reset,
  mm_cmd_responder_if.slave bus
);

  localparam int IDX_W = (SCRATCH_DEPTH > 1) ? $clog2(SCRATCH_DEPTH) : 1;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_DELAY = 8'h04;
  localparam logic [7:0] OP_TS    = 8'h05;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WAIT} state_e;

  state_e                  state_q, state_d;
  logic                    seq_seen_q, seq_seen_d;
  logic [7:0]              op_q, op_d;
  logic [31:0]             arg0_q, arg0_d;
  logic [31:0]             arg1_q, arg1_d;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic [DONE_CNT_W-1:0]   done_cnt_q, done_cnt_d;
  logic [7:0]              last_op_q, last_op_d;
  logic [31:0]             result0_q, result0_d;
  logic [31:0]             result1_q, result1_d;
  logic [31:0]             delay_q, delay_d;
  logic [63:0]             cyc_cnt_q;
  logic [31:0]             scratch_q [SCRATCH_DEPTH];

  logic                    scr_we;
  logic                    complete;
  logic [IDX_W-1:0]        scr_idx;
  logic [32:0]             sum;
  logic                    unused_cmd_bits;

  assign scr_idx         = arg0_q[IDX_W-1:0];
  assign sum             = {1'b0, arg0_q} + {1'b0, arg1_q};
  assign unused_cmd_bits = ^bus.cmd_i[30:8];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < SCRATCH_DEPTH; i++) begin
        scratch_q[i] <= '0;
      end
    end else if (scr_we) begin
      scratch_q[scr_idx] <= arg1_q;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= ST_IDLE;
      seq_seen_q <= 1'b0;
      op_q       <= '0;
      arg0_q     <= '0;
      arg1_q     <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
      last_op_q  <= '0;
      result0_q  <= '0;
      result1_q  <= '0;
      delay_q    <= '0;
    end else begin
      state_q    <= state_d;
      seq_seen_q <= seq_seen_d;
      op_q       <= op_d;
      arg0_q     <= arg0_d;
      arg1_q     <= arg1_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      done_cnt_q <= done_cnt_d;
      last_op_q  <= last_op_d;
      result0_q  <= result0_d;
      result1_q  <= result1_d;
      delay_q    <= delay_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_seen_d = seq_seen_q;
    op_d       = op_q;
    arg0_d     = arg0_q;
    arg1_d     = arg1_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    err_d      = err_q;
    done_cnt_d = done_cnt_q;
    last_op_d  = last_op_q;
    result0_d  = result0_q;
    result1_d  = result1_q;
    delay_d    = delay_q;
    scr_we     = 1'b0;
    complete   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Inputs are only sampled here, so toggles while busy are seen afterwards.
        if (bus.cmd_i[31] != seq_seen_q) begin
          op_d       = bus.cmd_i[7:0];
          arg0_d     = bus.arg0_i;
          arg1_d     = bus.arg1_i;
          seq_seen_d = bus.cmd_i[31];
          busy_d     = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        complete = 1'b1;
        err_d    = 1'b0;
        case (op_q)
          OP_NOP: begin
          end
          OP_READ: begin
            result0_d = scratch_q[scr_idx];
            result1_d = '0;
          end
          OP_WRITE: begin
            scr_we    = 1'b1;
            result0_d = arg1_q;
          end
          OP_ADD: begin
            result0_d = sum[31:0];
            result1_d = {31'b0, sum[32]};
          end
          OP_DELAY: begin
            delay_d = arg0_q;
            if (arg0_q != 32'd0) begin
              complete = 1'b0;
              state_d  = ST_WAIT;
            end
          end
          OP_TS: begin
            {result1_d, result0_d} = cyc_cnt_q;
          end
          default: begin
            err_d = 1'b1;
          end
        endcase
      end
      ST_WAIT: begin
        if (delay_q == 32'd1) begin
          complete = 1'b1;
        end else begin
          delay_d = delay_q - 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (complete) begin
      ack_d      = seq_seen_q;
      busy_d     = 1'b0;
      done_cnt_d = done_cnt_q + 1'b1;
      last_op_d  = op_q;
      state_d    = ST_IDLE;
    end
  end

  assign bus.status_o       = {ack_q, busy_q, err_q, 5'b0, 16'(done_cnt_q), last_op_q};
  assign bus.result0_o      = result0_q;
  assign bus.result1_o      = result1_q;
  assign bus.timestamp_lo_o = cyc_cnt_q[31:0];

endmodule

// File: tb/tb_mm_cmd_responder.sv
// Directed bench for mm_cmd_responder: a vector table of single commands plus
// hand-written sequences for delays, timestamps, overlapping toggles and reset.
module tb_mm_cmd_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mm_cmd_responder_if bus ();

  mm_cmd_responder #(.SCRATCH_DEPTH(8), .DONE_CNT_W(16)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] arg0;
    logic [31:0] arg1;
    logic        exp_busy;
    logic [31:0] exp_status;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  task automatic drive(input logic [31:0] cmd, input logic [31:0] a0, input logic [31:0] a1);
    bus.cmd_i  = cmd;
    bus.arg0_i = a0;
    bus.arg1_i = a1;
  endtask

  // Steps until busy drops; returns the number of steps taken (0 on timeout).
  task automatic wait_done(input string name, input int max_steps, output int steps);
    steps = 0;
    for (int i = 1; i <= max_steps; i++) begin
      step();
      if (bus.status_o[30] == 1'b0) begin
        steps = i;
        break;
      end
    end
    if (steps == 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: timeout after %0d cycles, busy still set", name, max_steps);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ts_a, ts_b;
    int          n;

    vecs[0]  = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{32'h8000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h8000_0103, 32'h0000_0001, 32'h0000_0001};
    vecs[2]  = '{32'h0000_0002, 32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0000_0001};
    vecs[3]  = '{32'h8000_0001, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h8000_0301, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[4]  = '{32'h0000_007F, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h2000_047F, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h8000_0500, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[6]  = '{32'h0000_0003, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0603, 32'h8000_0000, 32'h0000_0000};
    vecs[7]  = '{32'h8000_0001, 32'h0000_000D, 32'h0000_0000, 1'b1, 32'h8000_0701, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[8]  = '{32'h0000_0001, 32'h0000_0003, 32'h0000_0000, 1'b1, 32'h0000_0801, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{32'h8000_0004, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h8000_0904, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0A03, 32'hFFFF_FFFE, 32'h0000_0001};

    drive(32'h0, 32'h0, 32'h0);
    step();
    step();
    check("reset status", {32'h0, bus.status_o}, 64'h0);
    check("reset result0", {32'h0, bus.result0_o}, 64'h0);
    check("reset result1", {32'h0, bus.result1_o}, 64'h0);
    check("reset timestamp_lo", {32'h0, bus.timestamp_lo_o}, 64'h0);
    rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].cmd, vecs[v].arg0, vecs[v].arg1);
      step();
      check($sformatf("vec%0d busy", v), {63'h0, bus.status_o[30]}, {63'h0, vecs[v].exp_busy});
      step();
      check($sformatf("vec%0d status", v), {32'h0, bus.status_o}, {32'h0, vecs[v].exp_status});
      check($sformatf("vec%0d result0", v), {32'h0, bus.result0_o}, {32'h0, vecs[v].exp_r0});
      check($sformatf("vec%0d result1", v), {32'h0, bus.result1_o}, {32'h0, vecs[v].exp_r1});
    end

    // DELAY of 10: busy for 11 cycles, completion on the 12th edge.
    drive(32'h8000_0004, 32'd10, 32'h0);
    wait_done("delay10", 50, n);
    check("delay10 completion cycle", 64'(n), 64'd12);
    check("delay10 status", {32'h0, bus.status_o}, 64'h8000_0B04);

    // Two timestamps issued exactly 100 cycles apart.
    drive(32'h0000_0005, 32'h0, 32'h0);
    step();
    step();
    ts_a = {bus.result1_o, bus.result0_o};
    check("ts1 status", {32'h0, bus.status_o}, 64'h0000_0C05);
    for (int i = 0; i < 98; i++) step();
    drive(32'h8000_0005, 32'h0, 32'h0);
    step();
    step();
    ts_b = {bus.result1_o, bus.result0_o};
    check("ts difference", ts_b - ts_a, 64'd100);
    check("ts2 status", {32'h0, bus.status_o}, 64'h8000_0D05);

    // Counter preloaded just below 2^32: sampled value carries into result1.
    force dut.cyc_cnt_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cyc_cnt_q;
    drive(32'h0000_0005, 32'h0, 32'h0);
    step();
    step();
    check("ts carry result1", {32'h0, bus.result1_o}, 64'h1);
    check("ts carry result0", {32'h0, bus.result0_o}, 64'h0);
    check("ts carry status", {32'h0, bus.status_o}, 64'h0000_0E05);

    // Single toggle during a DELAY of 20 runs right after it completes.
    drive(32'h8000_0004, 32'd20, 32'h0);
    step();
    step();
    step();
    drive(32'h0000_0004, 32'd0, 32'h0);
    wait_done("delay20", 60, n);
    check("delay20 completion cycle", 64'(n + 3), 64'd22);
    check("delay20 status", {32'h0, bus.status_o}, 64'h8000_0F04);
    step();
    check("queued cmd busy", {32'h0, bus.status_o}, 64'hC000_0F04);
    step();
    check("queued cmd done", {32'h0, bus.status_o}, 64'h0000_1004);

    // Double toggle during busy is not seen.
    drive(32'h8000_0004, 32'd5, 32'h0);
    step();
    step();
    drive(32'h0000_0004, 32'd5, 32'h0);
    step();
    step();
    drive(32'h8000_0004, 32'd5, 32'h0);
    wait_done("delay5", 30, n);
    check("delay5 completion cycle", 64'(n + 4), 64'd7);
    for (int i = 0; i < 3; i++) step();
    check("double toggle ignored", {32'h0, bus.status_o}, 64'h8000_1104);

    // Reset asserted in the middle of a WAIT.
    drive(32'h0000_0004, 32'd20, 32'h0);
    for (int i = 0; i < 5; i++) step();
    check("pre-reset busy", {63'h0, bus.status_o[30]}, 64'h1);
    rst = 1'b1;
    #2;
    check("mid-reset status", {32'h0, bus.status_o}, 64'h0);
    check("mid-reset result0", {32'h0, bus.result0_o}, 64'h0);
    check("mid-reset result1", {32'h0, bus.result1_o}, 64'h0);
    check("mid-reset timestamp_lo", {32'h0, bus.timestamp_lo_o}, 64'h0);
    step();
    rst = 1'b0;
    step();
    step();
    step();
    check("post-reset timestamp_lo", {32'h0, bus.timestamp_lo_o}, 64'd3);
    check("post-reset idle", {32'h0, bus.status_o}, 64'h0);
    drive(32'h8000_0001, 32'd5, 32'h0);
    step();
    step();
    check("scratch cleared", {32'h0, bus.result0_o}, 64'h0);
    check("post-reset read status", {32'h0, bus.status_o}, 64'h8000_0101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
